udatapath_seq_regfile: RTL and testbench
========================================

// Module: udatapath_seq_regfile
// PURPOSE
//  Next-generation datapath core: parametrised register file (index 0 hardwired to zero),
//  two read buses A/B and one write bus C, each indexed by control or by an internal IR field.
//  Feeds a registered ALU with latched N/Z/V/C flags, plus a multi-cycle 1-bit/cycle barrel-less
//  shifter behind a valid/ready issue handshake. Sits under the control unit in place of the fixed datapath.
// PARAMETERS
//  DATAWIDTH_BUS        32  data/register width
//  REG_COUNT            8   implemented registers r0..r(REG_COUNT-1), 2..32
//  REG_ADDR_WIDTH       5   register index width (IR fields and control indices)
//  IR_FIELD_A_LSB       14  LSB of rs1 field in IR
//  IR_FIELD_B_LSB       0   LSB of rs2 field in IR
//  IR_FIELD_C_LSB       25  LSB of rd field in IR
//  DATAWIDTH_ALU_SELECTION 4 ALU opcode width
// PORTS
//  uDATAPATH_CLOCK_50        in  1    clock, all state on rising edge
//  uDATAPATH_RESET_InHigh    in  1    synchronous reset, active-high
//  uDATAPATH_op_valid_InHigh in  1    operation request
//  uDATAPATH_op_ready_OutHigh out 1   datapath can accept an operation (IDLE)
//  uDATAPATH_done_OutHigh    out 1    one-cycle pulse: result written
//  uDATAPATH_aluselection_InBUS in 4  ALU opcode
//  uDATAPATH_setcc_InHigh    in  1    update flags with this operation
//  uDATAPATH_indexA/B/C_InBUS in REG_ADDR_WIDTH  control-supplied indices
//  uDATAPATH_selA/B/C_InHigh in  1    1: take index from IR field, 0: from control
//  uDATAPATH_irload_InHigh   in  1    load IR from uDATAPATH_irdata_InBUS
//  uDATAPATH_irdata_InBUS    in  DATAWIDTH_BUS  instruction word
//  uDATAPATH_data_OutBUS     out DATAWIDTH_BUS  last result written (registered)
//  uDATAPATH_flags_OutBUS    out 4    registered {N,Z,V,C}, active-high
// BEHAVIOUR
//  Reset: all registers, IR, data_OutBUS, flags = 0; state IDLE; ready=1; done=0. Reset mid-shift aborts, no write.
//  Index resolve: idx = sel ? IR[LSB+REG_ADDR_WIDTH-1:LSB] : control index; sampled at acceptance.
//  Reads: index 0 or >= REG_COUNT read 0. Writes to index 0 or >= REG_COUNT discarded (done still pulses).
//  Accept when valid && ready at edge t0; operands, opcode, rd, setcc captured at t0.
//  Opcodes: 0 ADD, 1 SUB(A-B), 2 AND, 3 OR, 4 XOR, 5 ANDN(A&~B), 6 ORN, 7 XNOR, 8 PASSA, 9 PASSB,
//   10 SLL, 11 SRL, 12 SRA (amount = B[4:0] mod DATAWIDTH); 13-15 result 0.
//  Single-cycle ops (0-9, 13-15, shift amount 0): rd and data_OutBUS written at t0; ready stays 1; done=1 in cycle after t0.
//  FSM IDLE->SHIFT on shift op with amount n>0: shreg<=A, cnt<=n, ready=0 from t0.
//   SHIFT: each edge shreg shifts 1 (SLL zero-fill, SRL zero-fill, SRA sign-fill), cnt--;
//   at edge where cnt==1: rd/data_OutBUS written with final value, ->IDLE. n edges busy; done in cycle after.
//  Flags (only if setcc, latched with the result write): N=res[MSB], Z=(res==0);
//   ADD: C=carry-out, V=signed overflow; SUB: C=borrow (A<B unsigned), V=signed overflow;
//   shifts: C=last bit shifted out (0 if n=0), V=0; logic/pass: V=C=0.
//  IR: irload honoured only in IDLE; same-cycle irload+accept -> op uses old IR, IR updates at t0. Ignored while busy.
//  Write/read same register same cycle: readers see old value (no bypass needed, reads after edge see new).
//  valid while ready=0: ignored, not queued.
// TESTING
//  reset; load r1=5 (PASSB path via preload op), r2=3; ADD rd=r3 setcc -> r3=8, flags 0000, done 1 cycle after.
//  r1=0x7FFFFFFF, r2=1, ADD setcc -> 0x80000000, flags N=1,V=1,Z=0,C=0; SUB r2-r2 setcc -> 0, Z=1.
//  r1=0x80000001, B amount=4, SRA setcc -> ready low 4 cycles, result 0xF8000000, C=0, done after 4th edge.
//  SLL amount 0 -> single-cycle, result=A, C=0; write to r0 or index 9 (REG_COUNT=8) -> reads stay 0.
//  IR=0x02004000 (rd=1, rs1=1), selA=selC=1, PASSA -> r1 unchanged; irload+valid same cycle uses old IR.
//  SRL amount 20 started, reset asserted at 3rd busy cycle -> no rd write, ready=1, all regs 0 next cycle.

Source files
------------

// File: rtl/udatapath_seq_regfile_if.sv
// Datapath control/result bus between the control unit and udatapath_seq_regfile.
//   master : control unit side (drives requests, indices, IR data)
//   slave  : datapath side (drives ready, done, result and flags)
// Signals:
//   op_valid / op_ready      : issue handshake, accepted when both high at a rising edge
//   done                     : one-cycle pulse after the result write
//   aluselection, setcc      : opcode and flag-update enable for the issued operation
//   indexA/B/C, selA/B/C     : control-supplied register indices; sel=1 takes the IR field
//   irload, irdata           : instruction register load
//   data, flags              : last written result and latched {N,Z,V,C}
interface udatapath_seq_regfile_if #(
  parameter int DATAWIDTH_BUS           = 32,
  parameter int REG_ADDR_WIDTH          = 5,
  parameter int DATAWIDTH_ALU_SELECTION = 4
);
  logic                               uDATAPATH_op_valid_InHigh;
  logic                               uDATAPATH_op_ready_OutHigh;
  logic                               uDATAPATH_done_OutHigh;
  logic [DATAWIDTH_ALU_SELECTION-1:0] uDATAPATH_aluselection_InBUS;
  logic                               uDATAPATH_setcc_InHigh;
  logic [REG_ADDR_WIDTH-1:0]          uDATAPATH_indexA_InBUS;
  logic [REG_ADDR_WIDTH-1:0]          uDATAPATH_indexB_InBUS;
  logic [REG_ADDR_WIDTH-1:0]          uDATAPATH_indexC_InBUS;
  logic                               uDATAPATH_selA_InHigh;
  logic                               uDATAPATH_selB_InHigh;
  logic                               uDATAPATH_selC_InHigh;
  logic                               uDATAPATH_irload_InHigh;
  logic [DATAWIDTH_BUS-1:0]           uDATAPATH_irdata_InBUS;
  logic [DATAWIDTH_BUS-1:0]           uDATAPATH_data_OutBUS;
  logic [3:0]                         uDATAPATH_flags_OutBUS;

  modport master (
    output uDATAPATH_op_valid_InHigh, uDATAPATH_aluselection_InBUS, uDATAPATH_setcc_InHigh,
           uDATAPATH_indexA_InBUS, uDATAPATH_indexB_InBUS, uDATAPATH_indexC_InBUS,
           uDATAPATH_selA_InHigh, uDATAPATH_selB_InHigh, uDATAPATH_selC_InHigh,
           uDATAPATH_irload_InHigh, uDATAPATH_irdata_InBUS,
    input  uDATAPATH_op_ready_OutHigh, uDATAPATH_done_OutHigh,
           uDATAPATH_data_OutBUS, uDATAPATH_flags_OutBUS
  );

  modport slave (
    input  uDATAPATH_op_valid_InHigh, uDATAPATH_aluselection_InBUS, uDATAPATH_setcc_InHigh,
           uDATAPATH_indexA_InBUS, uDATAPATH_indexB_InBUS, uDATAPATH_indexC_InBUS,
           uDATAPATH_selA_InHigh, uDATAPATH_selB_InHigh, uDATAPATH_selC_InHigh,
           uDATAPATH_irload_InHigh, uDATAPATH_irdata_InBUS,
    output uDATAPATH_op_ready_OutHigh, uDATAPATH_done_OutHigh,
           uDATAPATH_data_OutBUS, uDATAPATH_flags_OutBUS
  );
endinterface

// File: rtl/udatapath_seq_regfile.sv
// Register-file datapath: r0 hardwired to zero, two read ports (A/B) and one write
// port (C), each indexed either by control or by an IR field. Single-cycle ALU ops
// write at the accept edge; SLL/SRL/SRA with a non-zero amount run one bit per cycle
// in the SHIFT state with ready held low.
// Ports:
//   uDATAPATH_CLOCK_50     : clock, all state on the rising edge
//   uDATAPATH_RESET_InHigh : synchronous active-high reset (clears regs, IR, outputs, FSM)
//   bus                    : udatapath_seq_regfile_if.slave (handshake, indices, IR, result, flags)
module udatapath_seq_regfile #(
  parameter int DATAWIDTH_BUS           = 32,
  parameter int REG_COUNT               = 8,
  parameter int REG_ADDR_WIDTH          = 5,
  parameter int IR_FIELD_A_LSB          = 14,
  parameter int IR_FIELD_B_LSB          = 0,
  parameter int IR_FIELD_C_LSB          = 25,
  parameter int DATAWIDTH_ALU_SELECTION = 4
) (
  input logic                    uDATAPATH_CLOCK_50,
  input logic                    uDATAPATH_RESET_InHigh,
  udatapath_seq_regfile_if.slave bus
);
  localparam int MSB = DATAWIDTH_BUS - 1;
  localparam int SHW = $clog2(DATAWIDTH_BUS);

  typedef logic [DATAWIDTH_ALU_SELECTION-1:0] opcode_t;
  localparam opcode_t OP_ADD   = opcode_t'(0);
  localparam opcode_t OP_SUB   = opcode_t'(1);
  localparam opcode_t OP_AND   = opcode_t'(2);
  localparam opcode_t OP_OR    = opcode_t'(3);
  localparam opcode_t OP_XOR   = opcode_t'(4);
  localparam opcode_t OP_ANDN  = opcode_t'(5);
  localparam opcode_t OP_ORN   = opcode_t'(6);
  localparam opcode_t OP_XNOR  = opcode_t'(7);
  localparam opcode_t OP_PASSA = opcode_t'(8);
  localparam opcode_t OP_PASSB = opcode_t'(9);
  localparam opcode_t OP_SLL   = opcode_t'(10);
  localparam opcode_t OP_SRL   = opcode_t'(11);
  localparam opcode_t OP_SRA   = opcode_t'(12);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                    state, stateNext;
  logic [DATAWIDTH_BUS-1:0]  regFile [1:REG_COUNT-1];
  logic [DATAWIDTH_BUS-1:0]  ir;
  logic [DATAWIDTH_BUS-1:0]  dataOut;
  logic [3:0]                flags;
  logic                      done;

  // Captured shift operation, held while in SHIFT
  logic signed [MSB:0]       shiftReg_p1;
  logic [SHW-1:0]            cnt_p1;
  opcode_t                   op_p1;
  logic [REG_ADDR_WIDTH-1:0] rd_p1;
  logic                      setcc_p1;

  logic [REG_ADDR_WIDTH-1:0] idxA, idxB, idxC;
  logic [DATAWIDTH_BUS-1:0]  opA, opB;
  logic [DATAWIDTH_BUS:0]    sumExt, difExt;
  logic [DATAWIDTH_BUS-1:0]  aluRes;
  logic                      aluV, aluC;
  logic                      isIdle, accept, isShiftOp, startShift;
  logic [SHW-1:0]            shAmt;
  logic signed [MSB:0]       shiftNext;
  logic                      shiftOut;
  logic                      wrEn, flagsEn;
  logic [REG_ADDR_WIDTH-1:0] wrIdx;
  logic [DATAWIDTH_BUS-1:0]  wrData;
  logic [3:0]                flagsNew;
  logic                      unusedIrBits;

  assign isIdle = (state == IDLE);
  assign accept = bus.uDATAPATH_op_valid_InHigh && isIdle;

  // IR fields are taken from the IR as it stands before this edge, so a same-cycle
  // irload only affects the following operation.
  assign idxA = bus.uDATAPATH_selA_InHigh ? ir[IR_FIELD_A_LSB +: REG_ADDR_WIDTH] : bus.uDATAPATH_indexA_InBUS;
  assign idxB = bus.uDATAPATH_selB_InHigh ? ir[IR_FIELD_B_LSB +: REG_ADDR_WIDTH] : bus.uDATAPATH_indexB_InBUS;
  assign idxC = bus.uDATAPATH_selC_InHigh ? ir[IR_FIELD_C_LSB +: REG_ADDR_WIDTH] : bus.uDATAPATH_indexC_InBUS;
  assign unusedIrBits = ^ir;

  // Index 0 and indices beyond the implemented file match no entry and read zero.
  always_comb begin
    opA = '0;
    opB = '0;
    for (int i = 1; i < REG_COUNT; i++) begin
      if (idxA == REG_ADDR_WIDTH'(i)) opA = regFile[i];
      if (idxB == REG_ADDR_WIDTH'(i)) opB = regFile[i];
    end
  end

  assign shAmt      = opB[SHW-1:0];
  assign isShiftOp  = (bus.uDATAPATH_aluselection_InBUS == OP_SLL) ||
                      (bus.uDATAPATH_aluselection_InBUS == OP_SRL) ||
                      (bus.uDATAPATH_aluselection_InBUS == OP_SRA);
  assign startShift = accept && isShiftOp && (shAmt != '0);

  // Single-cycle ALU; a shift reaching this result path has amount 0 and passes A.
  always_comb begin
    aluRes = '0;
    aluV   = 1'b0;
    aluC   = 1'b0;
    sumExt = {1'b0, opA} + {1'b0, opB};
    difExt = {1'b0, opA} - {1'b0, opB};
    case (bus.uDATAPATH_aluselection_InBUS)
      OP_ADD: begin
        aluRes = sumExt[MSB:0];
        aluC   = sumExt[DATAWIDTH_BUS];
        aluV   = (opA[MSB] == opB[MSB]) && (aluRes[MSB] != opA[MSB]);
      end
      OP_SUB: begin
        aluRes = difExt[MSB:0];
        aluC   = difExt[DATAWIDTH_BUS];  // borrow: A < B unsigned
        aluV   = (opA[MSB] != opB[MSB]) && (aluRes[MSB] != opA[MSB]);
      end
      OP_AND:   aluRes = opA & opB;
      OP_OR:    aluRes = opA | opB;
      OP_XOR:   aluRes = opA ^ opB;
      OP_ANDN:  aluRes = opA & ~opB;
      OP_ORN:   aluRes = opA | ~opB;
      OP_XNOR:  aluRes = ~(opA ^ opB);
      OP_PASSA: aluRes = opA;
      OP_PASSB: aluRes = opB;
      OP_SLL, OP_SRL, OP_SRA: aluRes = opA;
      default:  aluRes = '0;
    endcase
  end

  // One-bit shift step; shiftOut is the bit leaving the register on this edge.
  always_comb begin
    case (op_p1)
      OP_SLL: begin
        shiftNext = shiftReg_p1 <<< 1;
        shiftOut  = shiftReg_p1[MSB];
      end
      OP_SRL: begin
        shiftNext = shiftReg_p1 >> 1;
        shiftOut  = shiftReg_p1[0];
      end
      default: begin
        shiftNext = shiftReg_p1 >>> 1;
        shiftOut  = shiftReg_p1[0];
      end
    endcase
  end

  // FSM next state plus write/flag selection
  always_comb begin
    stateNext = state;
    wrEn      = 1'b0;
    wrIdx     = idxC;
    wrData    = aluRes;
    flagsEn   = 1'b0;
    flagsNew  = {aluRes[MSB], (aluRes == '0), aluV, aluC};
    case (state)
      IDLE: begin
        if (startShift) begin
          stateNext = SHIFT;
        end else if (accept) begin
          wrEn    = 1'b1;
          flagsEn = bus.uDATAPATH_setcc_InHigh;
        end
      end
      SHIFT: begin
        if (cnt_p1 == SHW'(1)) begin
          stateNext = IDLE;
          wrEn      = 1'b1;
          wrIdx     = rd_p1;
          wrData    = shiftNext;
          flagsEn   = setcc_p1;
          flagsNew  = {shiftNext[MSB], (shiftNext == '0), 1'b0, shiftOut};
        end
      end
    endcase
  end

  // Stage boundary: accept edge captures operands / shift state; results land here
  always_ff @(posedge uDATAPATH_CLOCK_50) begin
    if (uDATAPATH_RESET_InHigh) begin
      state       <= IDLE;
      ir          <= '0;
      dataOut     <= '0;
      flags       <= '0;
      done        <= 1'b0;
      shiftReg_p1 <= '0;
      cnt_p1      <= '0;
      op_p1       <= OP_ADD;
      rd_p1       <= '0;
      setcc_p1    <= 1'b0;
      for (int i = 1; i < REG_COUNT; i++) regFile[i] <= '0;
    end else begin
      state <= stateNext;
      done  <= wrEn;
      if (isIdle && bus.uDATAPATH_irload_InHigh) ir <= bus.uDATAPATH_irdata_InBUS;
      if (startShift) begin
        shiftReg_p1 <= opA;
        cnt_p1      <= shAmt;
        op_p1       <= bus.uDATAPATH_aluselection_InBUS;
        rd_p1       <= idxC;
        setcc_p1    <= bus.uDATAPATH_setcc_InHigh;
      end else if (!isIdle) begin
        shiftReg_p1 <= shiftNext;
        cnt_p1      <= cnt_p1 - SHW'(1);
      end
      // Writes to r0 or out-of-range indices match nothing; the result still shows on data.
      if (wrEn) begin
        dataOut <= wrData;
        for (int i = 1; i < REG_COUNT; i++) begin
          if (wrIdx == REG_ADDR_WIDTH'(i)) regFile[i] <= wrData;
        end
      end
      if (flagsEn) flags <= flagsNew;
    end
  end

  assign bus.uDATAPATH_op_ready_OutHigh = isIdle;
  assign bus.uDATAPATH_done_OutHigh     = done;
  assign bus.uDATAPATH_data_OutBUS      = dataOut;
  assign bus.uDATAPATH_flags_OutBUS     = flags;
endmodule

// File: tb/tb_udatapath_seq_regfile.sv
// Directed bench for udatapath_seq_regfile: a vector table of ALU/shift operations
// with hand-computed results, flags and latencies, plus hand-written sequences for
// the busy window, IR index selection and reset during a shift.
module tb_udatapath_seq_regfile;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  udatapath_seq_regfile_if dpBus ();

  udatapath_seq_regfile dut (
    .uDATAPATH_CLOCK_50    (clk),
    .uDATAPATH_RESET_InHigh(rst),
    .bus                   (dpBus)
  );

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4, OP_ANDN = 4'd5, OP_ORN = 4'd6, OP_XNOR = 4'd7;
  localparam logic [3:0] OP_PASSA = 4'd8, OP_PASSB = 4'd9, OP_SLL = 4'd10, OP_SRL = 4'd11;
  localparam logic [3:0] OP_SRA = 4'd12, OP_NONE = 4'd13;

  typedef struct {
    logic [3:0]  op;
    int          a;
    int          b;
    int          c;
    logic        sc;
    logic [31:0] expData;
    logic [3:0]  expFlags;
    int          expLat;
  } vec_t;

  vec_t vecs[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    dpBus.uDATAPATH_op_valid_InHigh    = 1'b0;
    dpBus.uDATAPATH_aluselection_InBUS = OP_NONE;
    dpBus.uDATAPATH_setcc_InHigh       = 1'b0;
    dpBus.uDATAPATH_indexA_InBUS       = '0;
    dpBus.uDATAPATH_indexB_InBUS       = '0;
    dpBus.uDATAPATH_indexC_InBUS       = '0;
    dpBus.uDATAPATH_selA_InHigh        = 1'b0;
    dpBus.uDATAPATH_selB_InHigh        = 1'b0;
    dpBus.uDATAPATH_selC_InHigh        = 1'b0;
    dpBus.uDATAPATH_irload_InHigh      = 1'b0;
    dpBus.uDATAPATH_irdata_InBUS       = '0;
  endtask

  task automatic setOp(input logic [3:0] op, input int ia, input int ib, input int ic, input logic sc);
    dpBus.uDATAPATH_aluselection_InBUS = op;
    dpBus.uDATAPATH_indexA_InBUS       = 5'(ia);
    dpBus.uDATAPATH_indexB_InBUS       = 5'(ib);
    dpBus.uDATAPATH_indexC_InBUS       = 5'(ic);
    dpBus.uDATAPATH_setcc_InHigh       = sc;
  endtask

  // Called at a sample point (#1 after a rising edge) with the datapath idle.
  task automatic runOp(input logic [3:0] op, input int ia, input int ib, input int ic, input logic sc,
                       input logic sa, input logic sb, input logic scl, input logic irl,
                       input logic [31:0] ird,
                       output logic [31:0] data, output logic [3:0] fl, output int lat);
    setOp(op, ia, ib, ic, sc);
    dpBus.uDATAPATH_selA_InHigh   = sa;
    dpBus.uDATAPATH_selB_InHigh   = sb;
    dpBus.uDATAPATH_selC_InHigh   = scl;
    dpBus.uDATAPATH_irload_InHigh = irl;
    dpBus.uDATAPATH_irdata_InBUS  = ird;
    dpBus.uDATAPATH_op_valid_InHigh = 1'b1;
    @(posedge clk); #1;
    idleInputs();
    lat = 0;
    while (!dpBus.uDATAPATH_done_OutHigh && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check("done seen", {31'b0, dpBus.uDATAPATH_done_OutHigh}, 32'd1);
    data = dpBus.uDATAPATH_data_OutBUS;
    fl   = dpBus.uDATAPATH_flags_OutBUS;
  endtask

  task automatic runCtl(input logic [3:0] op, input int ia, input int ib, input int ic, input logic sc,
                        output logic [31:0] data, output logic [3:0] fl, output int lat);
    runOp(op, ia, ib, ic, sc, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, data, fl, lat);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [3:0]  f;
    int          lat;

    idleInputs();
    // op, A, B, C, setcc, data, {N,Z,V,C}, edges until done
    vecs.push_back('{OP_XNOR,  0, 0, 1, 1'b1, 32'hFFFFFFFF, 4'b1000,  0});
    vecs.push_back('{OP_SRL,   1, 1, 2, 1'b1, 32'h00000001, 4'b0001, 31});
    vecs.push_back('{OP_ADD,   2, 2, 3, 1'b1, 32'h00000002, 4'b0000,  0});
    vecs.push_back('{OP_ADD,   3, 2, 4, 1'b1, 32'h00000003, 4'b0000,  0});
    vecs.push_back('{OP_ADD,   4, 3, 5, 1'b1, 32'h00000005, 4'b0000,  0});
    vecs.push_back('{OP_PASSB, 0, 5, 6, 1'b0, 32'h00000005, 4'b0000,  0});
    vecs.push_back('{OP_ADD,   6, 4, 7, 1'b1, 32'h00000008, 4'b0000,  0});
    vecs.push_back('{OP_SRL,   1, 2, 3, 1'b1, 32'h7FFFFFFF, 4'b0001,  1});
    vecs.push_back('{OP_ADD,   3, 2, 7, 1'b1, 32'h80000000, 4'b1010,  0});
    vecs.push_back('{OP_SUB,   4, 4, 6, 1'b1, 32'h00000000, 4'b0100,  0});
    vecs.push_back('{OP_SUB,   2, 4, 6, 1'b1, 32'hFFFFFFFE, 4'b1001,  0});
    vecs.push_back('{OP_SUB,   7, 2, 6, 1'b1, 32'h7FFFFFFF, 4'b0010,  0});
    vecs.push_back('{OP_SLL,   1, 1, 6, 1'b1, 32'h80000000, 4'b1001, 31});
    vecs.push_back('{OP_SLL,   7, 0, 5, 1'b1, 32'h80000000, 4'b1000,  0});
    vecs.push_back('{OP_OR,    6, 2, 6, 1'b1, 32'h80000001, 4'b1000,  0});
    vecs.push_back('{OP_ADD,   4, 2, 3, 1'b1, 32'h00000004, 4'b0000,  0});
    vecs.push_back('{OP_XOR,   1, 4, 5, 1'b1, 32'hFFFFFFFC, 4'b1000,  0});
    vecs.push_back('{OP_ANDN,  4, 2, 5, 1'b1, 32'h00000002, 4'b0000,  0});
    vecs.push_back('{OP_AND,   4, 2, 5, 1'b1, 32'h00000001, 4'b0000,  0});
    vecs.push_back('{OP_ORN,   0, 4, 5, 1'b1, 32'hFFFFFFFC, 4'b1000,  0});
    vecs.push_back('{OP_NONE,  1, 1, 5, 1'b1, 32'h00000000, 4'b0100,  0});
    vecs.push_back('{OP_PASSA, 7, 0, 0, 1'b0, 32'h80000000, 4'b0100,  0});
    vecs.push_back('{OP_PASSA, 0, 0, 0, 1'b1, 32'h00000000, 4'b0100,  0});
    vecs.push_back('{OP_PASSA, 7, 0, 9, 1'b0, 32'h80000000, 4'b0100,  0});
    vecs.push_back('{OP_PASSA, 9, 0, 0, 1'b1, 32'h00000000, 4'b0100,  0});

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", {31'b0, dpBus.uDATAPATH_op_ready_OutHigh}, 32'd1);
    check("reset done",  {31'b0, dpBus.uDATAPATH_done_OutHigh},     32'd0);
    check("reset data",  dpBus.uDATAPATH_data_OutBUS,               32'h0);
    check("reset flags", {28'b0, dpBus.uDATAPATH_flags_OutBUS},     32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      runCtl(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].sc, d, f, lat);
      check($sformatf("vec%0d data", i),  d,             vecs[i].expData);
      check($sformatf("vec%0d flags", i), {28'b0, f},    {28'b0, vecs[i].expFlags});
      check($sformatf("vec%0d lat", i),   32'(lat),      32'(vecs[i].expLat));
      @(posedge clk); #1;
    end

    // SRA 0x80000001 by 4: busy for 4 cycles, a request during the window is dropped
    setOp(OP_SRA, 6, 3, 7, 1'b1);
    dpBus.uDATAPATH_op_valid_InHigh = 1'b1;
    @(posedge clk); #1;
    dpBus.uDATAPATH_op_valid_InHigh = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("sra busy%0d ready", k), {31'b0, dpBus.uDATAPATH_op_ready_OutHigh}, 32'd0);
      check($sformatf("sra busy%0d done", k),  {31'b0, dpBus.uDATAPATH_done_OutHigh},     32'd0);
      if (k == 1) begin
        setOp(OP_PASSA, 1, 0, 4, 1'b0);
        dpBus.uDATAPATH_op_valid_InHigh = 1'b1;
      end else begin
        dpBus.uDATAPATH_op_valid_InHigh = 1'b0;
      end
      @(posedge clk); #1;
    end
    idleInputs();
    check("sra done",  {31'b0, dpBus.uDATAPATH_done_OutHigh},     32'd1);
    check("sra ready", {31'b0, dpBus.uDATAPATH_op_ready_OutHigh}, 32'd1);
    check("sra data",  dpBus.uDATAPATH_data_OutBUS,               32'hF8000000);
    check("sra flags", {28'b0, dpBus.uDATAPATH_flags_OutBUS},     32'h8);
    @(posedge clk); #1;
    runCtl(OP_PASSA, 4, 0, 0, 1'b0, d, f, lat);
    check("busy request dropped r4", d, 32'h00000003);

    // IR index selection: IR=0x02004000 gives rd=1, rs1=1
    dpBus.uDATAPATH_irload_InHigh = 1'b1;
    dpBus.uDATAPATH_irdata_InBUS  = 32'h02004000;
    @(posedge clk); #1;
    idleInputs();
    runOp(OP_PASSA, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, d, f, lat);
    check("ir passa data", d, 32'hFFFFFFFF);
    runCtl(OP_PASSA, 1, 0, 0, 1'b0, d, f, lat);
    check("ir r1 unchanged", d, 32'hFFFFFFFF);
    // irload with accept: this op still sees rs1=1; next op sees rs1=6, rd=5, rs2=2
    runOp(OP_PASSA, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0A018002, d, f, lat);
    check("ir same-cycle old", d, 32'hFFFFFFFF);
    runOp(OP_PASSA, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, d, f, lat);
    check("ir new rs1", d, 32'h80000001);
    runCtl(OP_PASSA, 5, 0, 0, 1'b0, d, f, lat);
    check("ir new rd r5", d, 32'h80000001);
    runOp(OP_PASSB, 0, 7, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, d, f, lat);
    check("ir rs2 selB", d, 32'h00000001);

    // Build shift amount 20 in r5, start SRL 20, reset on the 3rd busy cycle
    runCtl(OP_ADD, 2, 2, 5, 1'b0, d, f, lat);
    runCtl(OP_SLL, 3, 5, 5, 1'b0, d, f, lat);
    check("amt16 lat", 32'(lat), 32'd2);
    runCtl(OP_ADD, 5, 3, 5, 1'b0, d, f, lat);
    check("amt20", d, 32'd20);
    setOp(OP_SRL, 1, 5, 6, 1'b1);
    dpBus.uDATAPATH_op_valid_InHigh = 1'b1;
    @(posedge clk); #1;
    idleInputs();
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("srl20 busy", {31'b0, dpBus.uDATAPATH_op_ready_OutHigh}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort ready", {31'b0, dpBus.uDATAPATH_op_ready_OutHigh}, 32'd1);
    check("abort done",  {31'b0, dpBus.uDATAPATH_done_OutHigh},     32'd0);
    check("abort data",  dpBus.uDATAPATH_data_OutBUS,               32'h0);
    check("abort flags", {28'b0, dpBus.uDATAPATH_flags_OutBUS},     32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    runCtl(OP_PASSA, 6, 0, 0, 1'b0, d, f, lat);
    check("abort r6", d, 32'h0);
    runCtl(OP_PASSA, 1, 0, 0, 1'b0, d, f, lat);
    check("abort r1", d, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
